// File: rtl/exe_wb_pkg.sv
// Shared types and helpers for the EXE-stage result collection / writeback arbiter.
package exe_wb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ROB_W  = 3;
  localparam int unsigned RD_W   = 7;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Queue entries are stored flat in this exact field order (data in the MSBs).
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ROB_W-1:0]  rob_idx;
    logic [RD_W-1:0]   rd;
  } wb_entry_t;

  // Distance from the ROB head; modulo arithmetic handles index wrap-around.
  function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] idx,
                                               input logic [ROB_W-1:0] head);
    return idx - head;
  endfunction

endpackage

// File: rtl/wb_chan_fifo.sv
// Per-channel result queue: circular buffer with a live bit per entry so that
// wrong-path results can be killed in place and drained silently from the head.
module wb_chan_fifo #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned ROB_W   = 3,
  parameter int unsigned RD_W    = 7,
  parameter int unsigned ENTRY_W = 42
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_entry,
  input  logic               pop,
  input  logic               flush,
  input  logic [ROB_W-1:0]   flush_rob_idx,
  input  logic [ROB_W-1:0]   rob_head,
  output logic               ready,
  output logic               nonempty,
  output logic               head_live,
  output logic [ENTRY_W-1:0] head_entry
);
  import exe_wb_pkg::*;

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]   live_q, live_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               head_dead, pop_all;
  logic [ROB_W-1:0]   flush_age;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign nonempty   = (count_q != '0);
  assign head_live  = nonempty & live_q[rd_ptr_q];
  assign head_dead  = nonempty & ~live_q[rd_ptr_q];
  assign head_entry = mem_q[rd_ptr_q];
  // Killed heads leave without a grant, one per cycle.
  assign pop_all    = pop | head_dead;
  // Registered count only: a same-cycle pop never raises ready.
  assign ready      = (count_q < CntW'(DEPTH));
  assign flush_age  = rob_age(flush_rob_idx, rob_head);

  // Next-state for live bits, pointers and occupancy.
  always_comb begin
    live_d = live_q;
    if (flush) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (rob_age(mem_q[k][RD_W +: ROB_W], rob_head) > flush_age) live_d[k] = 1'b0;
      end
    end
    if (pop_all) live_d[rd_ptr_q] = 1'b0;
    if (push)    live_d[wr_ptr_q] = 1'b1;
    rd_ptr_d = pop_all ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push    ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop_all);
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      live_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      live_q   <= live_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; validity is tracked by count/live, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/exe_wb_arbiter.sv
// EXE-stage result collection: per-FU queues, candidate mux with bypass,
// fixed-priority or round-robin grant, mispredict squash and the WB register.
module exe_wb_arbiter #(
  parameter int unsigned N_FU     = 8,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ROB_W    = 3,
  parameter int unsigned RD_W     = 7,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_FU-1:0]        fu_valid,
  input  logic [N_FU*DATA_W-1:0] fu_data,
  input  logic [N_FU*ROB_W-1:0]  fu_rob_idx,
  input  logic [N_FU*RD_W-1:0]   fu_rd,
  output logic [N_FU-1:0]        fu_ready,
  input  logic [ROB_W-1:0]       rob_head,
  input  logic                   flush,
  input  logic [ROB_W-1:0]       flush_rob_idx,
  output logic                   ex_out_valid,
  output logic [DATA_W-1:0]      ex_out_data,
  output logic [ROB_W-1:0]       ex_out_rob_idx,
  output logic [RD_W-1:0]        ex_out_rd,
  output logic [N_FU-1:0]        ex_out_sel,
  output logic                   wb_out_valid,
  output logic [DATA_W-1:0]      wb_out_data,
  output logic [ROB_W-1:0]       wb_out_rob_idx,
  output logic [RD_W-1:0]        wb_out_rd
);
  import exe_wb_pkg::*;

  localparam int unsigned EntryW = DATA_W + ROB_W + RD_W;
  localparam int unsigned SelW   = (N_FU > 1) ? $clog2(N_FU) : 1;

  logic [EntryW-1:0] in_entry   [N_FU];
  logic [EntryW-1:0] head_entry [N_FU];
  logic [EntryW-1:0] cand_entry [N_FU];
  logic [N_FU-1:0]   chan_ready, nonempty, head_live;
  logic [N_FU-1:0]   xfer, in_young, head_young, cand_valid;
  logic [N_FU-1:0]   grant, push, pop;
  logic              grant_any;
  logic [SelW-1:0]   grant_idx;
  logic [SelW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [EntryW-1:0] ex_entry;
  logic [ROB_W-1:0]  flush_age;

  assign flush_age = rob_age(flush_rob_idx, rob_head);

  for (genvar g = 0; g < N_FU; g++) begin : gen_chan
    assign in_entry[g] = {fu_data[g*DATA_W +: DATA_W], fu_rob_idx[g*ROB_W +: ROB_W],
                          fu_rd[g*RD_W +: RD_W]};

    wb_chan_fifo #(
      .DEPTH  (DEPTH),
      .ROB_W  (ROB_W),
      .RD_W   (RD_W),
      .ENTRY_W(EntryW)
    ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push         (push[g]),
      .push_entry   (in_entry[g]),
      .pop          (pop[g]),
      .flush        (flush),
      .flush_rob_idx(flush_rob_idx),
      .rob_head     (rob_head),
      .ready        (chan_ready[g]),
      .nonempty     (nonempty[g]),
      .head_live    (head_live[g]),
      .head_entry   (head_entry[g])
    );
  end

  assign fu_ready = chan_ready;

  // Per-channel candidate: queue head if anything is queued, else the bypass.
  always_comb begin
    for (int i = 0; i < int'(N_FU); i++) begin
      xfer[i]       = fu_valid[i] & chan_ready[i];
      in_young[i]   = flush & (rob_age(in_entry[i][RD_W +: ROB_W], rob_head) > flush_age);
      head_young[i] = flush & (rob_age(head_entry[i][RD_W +: ROB_W], rob_head) > flush_age);
      cand_valid[i] = nonempty[i] ? (head_live[i] & ~head_young[i])
                                  : (xfer[i] & ~in_young[i]);
      cand_entry[i] = nonempty[i] ? head_entry[i] : in_entry[i];
    end
  end

  // Single grant: scan from channel 0 (fixed) or from rr_ptr (round-robin).
  always_comb begin
    int idx;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < int'(N_FU); k++) begin
      idx = (ARB_MODE == ARB_RR) ? int'(rr_ptr_q) + k : k;
      if (idx >= int'(N_FU)) idx = idx - int'(N_FU);
      if (!grant_any && cand_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = SelW'(idx);
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
    rr_ptr_d = rr_ptr_q;
    if (grant_any) rr_ptr_d = (grant_idx == SelW'(N_FU - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Queue control: granted heads pop; transfers enqueue unless bypassed or squashed.
  always_comb begin
    for (int i = 0; i < int'(N_FU); i++) begin
      pop[i]  = grant[i] & nonempty[i];
      push[i] = xfer[i] & ~in_young[i] & ~(grant[i] & ~nonempty[i]);
    end
  end

  assign ex_entry       = grant_any ? cand_entry[grant_idx] : '0;
  assign ex_out_valid   = grant_any;
  assign ex_out_data    = ex_entry[EntryW-1 -: DATA_W];
  assign ex_out_rob_idx = ex_entry[RD_W +: ROB_W];
  assign ex_out_rd      = ex_entry[RD_W-1:0];
  assign ex_out_sel     = grant;

  // Round-robin pointer and writeback register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q       <= '0;
      wb_out_valid   <= 1'b0;
      wb_out_data    <= '0;
      wb_out_rob_idx <= '0;
      wb_out_rd      <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      wb_out_valid   <= ex_out_valid;
      wb_out_data    <= ex_out_data;
      wb_out_rob_idx <= ex_out_rob_idx;
      wb_out_rd      <= ex_out_rd;
    end
  end

endmodule

// File: doc/exe_wb_arbiter.md
# exe_wb_arbiter

Parametrised result-collection and writeback arbiter for the EXE stage. It accepts completed results from N_FU functional-unit channels and buffers each channel in its own DEPTH-entry queue. Each cycle it grants one result to the forwarding bus and registers it onto the WB bus. It adds three things to the single-entry, fixed-priority per-FU holding scheme: selectable round-robin arbitration, multi-entry per-channel buffering, and ROB-age-based squash of wrong-path results on mispredict.

## Interface
- N_FU, 8: number of result channels; channel index = fu_sel encoding.
- DEPTH, 2: entries per channel queue; must be ≥1.
- DATA_W, 32: result width.
- ROB_W, 3: ROB index width; the ROB has 2^ROB_W entries.
- RD_W, 7: physical destination register width.
- ARB_MODE, 0: 0 = fixed priority (lowest channel index wins); 1 = round-robin.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- fu_valid  in  N_FU  per-channel result valid.
- fu_data  in  N_FU*DATA_W  result data; channel i occupies slice [i*DATA_W +: DATA_W].
- fu_rob_idx  in  N_FU*ROB_W  result ROB index, sliced the same way.
- fu_rd  in  N_FU*RD_W  result destination, sliced the same way.
- fu_ready  out  N_FU  channel can accept a result this cycle.
- rob_head  in  ROB_W  oldest in-flight ROB index.
- flush  in  1  mispredict squash request.
- flush_rob_idx  in  ROB_W  ROB index of the mispredicting instruction.
- ex_out_valid / ex_out_data / ex_out_rob_idx / ex_out_rd  out  1/DATA_W/ROB_W/RD_W  granted result, combinational (forwarding bus).
- ex_out_sel  out  N_FU  one-hot grant; all zero when nothing is granted.
- wb_out_valid / wb_out_data / wb_out_rob_idx / wb_out_rd  out  1/DATA_W/ROB_W/RD_W  registered writeback.

## Operation
- Handshake: channel i transfers when fu_valid[i] && fu_ready[i]. fu_ready[i] = (count[i] < DEPTH). A pop in the same cycle does not raise ready. Results offered while not ready are ignored; the FU must hold them.
- Candidate for channel i: the queue head if count[i] > 0; otherwise the incoming transfer (bypass). Per-channel order is preserved.
- Arbitration: among live candidates, grant exactly one.
  - ARB_MODE 0: lowest index wins.
  - ARB_MODE 1: search starts at rr_ptr; after a grant to channel g, rr_ptr <= (g+1) mod N_FU; rr_ptr is unchanged if nothing is granted.
- Granted head: popped. Granted bypass: not enqueued. Ungranted bypass transfer: enqueued. Push and pop in the same cycle are both allowed when the queue is not full.
- Age: age(x) = (x − rob_head) mod 2^ROB_W. A result is younger than the flush when age(x) > age(flush_rob_idx). The flushing instruction's own result is kept.
- Flush cycle, all applied in the same cycle:
  - Every queued entry younger than the flush gets its live bit cleared.
  - An incoming transfer younger than the flush is accepted (fu_ready still obeys count) but dropped.
  - Younger candidates are excluded from arbitration.
- A dead head entry is popped automatically, one per channel per cycle, without a grant and without output. Dead entries count toward count[i] until popped.
- The wb register loads ex_out_* every cycle. A wb_out entry already registered before the flush is not retracted; the ROB discards it.
- Reset (rst == 0 at an edge):
  - All queues empty and all live bits cleared; rr_ptr = 0.
  - wb_out_valid = 0, wb_out_data = 0, wb_out_rob_idx = 0, wb_out_rd = 0.
  - fu_ready = all ones the cycle after reset.
  - Reset asserted mid-operation discards all buffered results.
- When nothing is granted, ex_out_valid = 0 and ex_out_data/rob_idx/rd are driven to 0.

## Timing
- Bypass latency: fu_valid at cycle t → ex_out_* at t (combinational), wb_out_* at t+1.
- Queued result: appears on ex_out in the first cycle it wins arbitration.
- Worst-case wait in ARB_MODE 1: a channel with a live head is granted within N_FU cycles.
- Combinational paths: fu_valid/fu_* → ex_out_*, and flush/rob_head → ex_out_*.
- fu_ready depends only on registered count; no combinational path from any input.
- Full: with count = DEPTH, fu_ready = 0 even if that head is granted this cycle.
- Wrap-around: age arithmetic is modulo 2^ROB_W. Test flush_rob_idx < rob_head.

## Structure
- Package exe_wb_pkg:
  - wb_entry_t packed struct {data, rob_idx, rd}; under the default parameters DATA_W, ROB_W and RD_W are package localparams.
  - Function rob_age(idx, head).
  - ARB_FIXED / ARB_RR constants.
- Sub-module wb_chan_fifo, instantiated N_FU times:
  - DEPTH circular buffer with per-entry live bit and count.
  - Provides push, pop, flush-kill, head-dead auto-pop, and ready.
- The top level holds the candidate mux, arbiter, rr_ptr, and wb register.

## Test plan
- Reset: hold rst=0 for 2 cycles → fu_ready=8'hFF, wb_out_valid=0, ex_out_sel=0.
- Bypass: ch0 valid, data=32'h1234, rob=3, rd=5, queues empty → same cycle ex_out_sel=8'h01, ex_out_data=32'h1234; next cycle wb_out_valid=1, wb_out_rd=5.
- Fixed-priority contention: ARB_MODE 0, DEPTH 2, ch1/ch3/ch6 all valid for 3 consecutive cycles.
  - Grants are ch1 ×3.
  - ch3 and ch6 fill their queues; fu_ready[3] and fu_ready[6] = 0 from cycle 3.
  - Draining order: ch3 (2 results), then ch6 (2 results).
- Round-robin: ARB_MODE 1, ch0/ch2/ch5 continuously valid → grant sequence 0,2,5,0,2,5.
- Flush with wrap:
  - Setup: rob_head=6; ch6 queue holds rob 7 and rob 1; ch0 bypass rob 0.
  - Stimulus: flush with flush_rob_idx=0.
  - Response: rob 1 killed and silently popped; rob 7 and rob 0 still written back; no output ever carries rob 1.
- Mid-operation reset: queues holding 3 results, rst=0 for one cycle → no further ex_out_valid; wb_out_valid=0.
